lcd_bus_decoder: RTL and testbench
==================================

# lcd_bus_decoder

Passive decoder for the 8-bit HD44780-style LCD write bus (E, RS, RW, LCD7..LCD0) driven by the stopwatch display path. It sits on the same bus as the LCD driver and sits alongside the panel. It decodes every transfer, maintains a 16-character model of line-1 DDRAM, and recovers the displayed time digits so the displayed time can be checked in hardware against the stopwatch counters. It also flags protocol violations: short E pulses, writes during the modelled busy time, and non-8-bit or read cycles.

## Interface
- TIME_ADDR, 4: DDRAM address of the H1 character. Layout is "HH:MM:SS" over TIME_ADDR..TIME_ADDR+7. Legal range is 0..8.
- MIN_E_HIGH, 12: minimum number of clk cycles E must be high.
- CMD_BUSY_CYC, 2000: modelled busy time after an ordinary command or a data write, in clk cycles.
- CLR_BUSY_CYC, 76000: modelled busy time after clear display (0x01) or return home (0x02/0x03).

- clk  input  1  single clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high.
- E, RS, RW  input  1 each  LCD bus strobe, register select, read/write.
- LCD7..LCD0  input  1 each  data bus; LCD7 is the MSB.
- H1, H0, M1, M0, S1, S0  output  4 each  low nibble of the character at time positions +0, +1, +3, +4, +6, +7.
- time_valid  output  1  high when all six positions hold '0'..'9' (0x30-0x39) and positions +2 and +5 hold ':' (0x3A).
- frame_done  output  1  one-cycle pulse after a data write lands on TIME_ADDR+7.
- disp_on  output  1  D bit of the last display-control command.
- err_timing, err_busy, err_mode  output  1 each  sticky error flags; only reset clears them.

## Operation
- Every cycle, E, RS, RW and the data bus are registered into e_q, rs_q, rw_q and d_q.
- A transfer is a falling edge: e_q=1 and E=0. The transfer uses rs_q, rw_q and d_q, i.e. the values from the last cycle E was high.
- E-high counter: counts cycles with e_q=1, saturates, and clears when e_q=0. If the count is below MIN_E_HIGH at the falling edge, set err_timing. The transfer is still applied.
- Busy counter: when nonzero it decrements by 1 per cycle. A transfer while it is nonzero sets err_busy; the transfer is still applied. After each write transfer the counter loads CLR_BUSY_CYC or CMD_BUSY_CYC according to the command type.
- rw_q=1 (read cycle): set err_mode. No state change and no busy reload.
- Commands (rs_q=0), first match from the MSB down:
  - 1xxxxxxx: addr = d[6:0]; select DDRAM mode.
  - 01xxxxxx: select CGRAM mode. Subsequent data writes are discarded but addr still steps.
  - 001xxxxx: function set. If DL (bit 4) is 0, set err_mode.
  - 0001xxxx: if bit 3 = 0, addr steps +1 when bit 2 = 1, else -1. If bit 3 = 1 (display shift), ignore.
  - 00001xxx: disp_on = bit 2.
  - 000001xx: ID = bit 1.
  - 0000001x: addr = 0; select DDRAM mode.
  - 00000001: all 16 chars = 0x20; addr = 0; ID = 1; select DDRAM mode.
  - 00000000: no operation, but the busy counter still reloads.
- Data (rs_q=1):
  - In DDRAM mode with addr < 16, write char[addr] = d_q. Otherwise nothing is stored.
  - Then addr steps +1 if ID=1, else -1.
- Address arithmetic: 7 bits, wraps modulo 128 (0x7F+1 = 0x00, 0x00-1 = 0x7F).
- The time outputs are recomputed from the character model every cycle and registered.

## Timing
- Reset values: all 16 chars = 0x20, addr=0, ID=1, DDRAM mode, e_q/rs_q/rw_q/d_q = 0, both counters = 0. All outputs are 0: H1..S0=0, time_valid=0, frame_done=0, disp_on=0, all err flags=0.
- Let edge t be the first rising edge at which E is sampled low after being high.
  - The character model, addr, ID, disp_on, the busy reload and the error flags all commit at edge t.
  - H1..S0 and time_valid reflect the new contents at edge t+1.
  - frame_done is high for exactly the cycle following edge t+1.
- Transfers need at least 2 cycles between falling edges: one cycle with E low, then at least one cycle high.
- Busy-counter collision: a transfer in the same cycle the counter reaches 0 is not an error. A transfer with the counter equal to 1 is an error.
- Reset has priority over everything. A falling edge in a reset cycle is lost.
- If E is high when reset deasserts: e_q becomes 1 on the next edge and the E-high count starts then. The following falling edge is decoded normally, and err_timing applies if that count is short.
- An error flag and a state change caused by the same transfer commit on the same edge.

## Test plan
- Reset, then idle for 100 cycles with E=0 → all outputs 0, time_valid=0, no frame_done.
- Send 0x38, 0x0C, 0x01, 0x06, 0x84, then data "12:34:56". E high 20 cycles per transfer, gaps above the busy limits → H1..S0 = 1,2,3,4,5,6. disp_on=1. time_valid=1 two cycles after the last E fall. One frame_done pulse. All err flags 0.
- From that state, send 0x8A then 0x37 → S1=7, time_valid stays 1. Then send 0x85 then 'A' (0x41) → H0=1, time_valid=0.
- E pulse of 5 cycles → err_timing=1 and the write still applied. Send 0x01, then a transfer 100 cycles later → err_busy=1.
- Send 0x28 → err_mode=1. Then an RW=1 pulse → characters unchanged and no busy reload.
- Send 0x04, 0x8B, '9', '8' → char[0x0B]='9', char[0x0A]='8', addr=0x09. Then assert reset during an E-high phase → all outputs 0 and chars blank on the next edge.

Source files
------------

// File: rtl/lcd_bus_decoder_if.sv
// LCD write-bus bundle: strobe, register select, read/write and 8-bit data.
interface lcd_bus_decoder_if;
  logic E;
  logic RS;
  logic RW;
  logic LCD7, LCD6, LCD5, LCD4, LCD3, LCD2, LCD1, LCD0;

  modport master (
    output E, RS, RW,
    output LCD7, LCD6, LCD5, LCD4, LCD3, LCD2, LCD1, LCD0
  );

  modport slave (
    input E, RS, RW,
    input LCD7, LCD6, LCD5, LCD4, LCD3, LCD2, LCD1, LCD0
  );
endinterface

// File: rtl/lcd_bus_decoder.sv
// Passive HD44780-style bus snooper: decodes every write on the falling edge
// of E, mirrors line-1 DDRAM (16 chars), recovers the "HH:MM:SS" digits and
// raises sticky flags on short E pulses, writes while busy and bad modes.
module lcd_bus_decoder #(
  parameter int TIME_ADDR    = 4,
  parameter int MIN_E_HIGH   = 12,
  parameter int CMD_BUSY_CYC = 2000,
  parameter int CLR_BUSY_CYC = 76000
) (
  input  logic                clk,
  input  logic                reset,
  lcd_bus_decoder_if.slave    bus,
  output logic [3:0]          H1,
  output logic [3:0]          H0,
  output logic [3:0]          M1,
  output logic [3:0]          M0,
  output logic [3:0]          S1,
  output logic [3:0]          S0,
  output logic                time_valid,
  output logic                frame_done,
  output logic                disp_on,
  output logic                err_timing,
  output logic                err_busy,
  output logic                err_mode
);

  localparam int NCHR     = 16;
  localparam int BUSY_MAX = (CLR_BUSY_CYC > CMD_BUSY_CYC) ? CLR_BUSY_CYC : CMD_BUSY_CYC;
  localparam int BUSY_W   = $clog2(BUSY_MAX + 1);
  localparam int EHI_MAX  = (MIN_E_HIGH > 1) ? MIN_E_HIGH - 1 : 0;
  localparam int EHI_W    = $clog2(MIN_E_HIGH + 2);

  // address-target mode (one-bit state)
  localparam logic [0:0] MODE_DDRAM = 1'b0;
  localparam logic [0:0] MODE_CGRAM = 1'b1;

  // bus input registers
  logic              r_e_q, r_rs_q, r_rw_q;
  logic [7:0]        r_d_q;
  logic [7:0]        w_d;

  // protocol tracking
  logic [EHI_W-1:0]  r_ehi;
  logic [BUSY_W-1:0] r_busy;

  // display model
  logic [NCHR-1:0][7:0] r_chr;
  logic [6:0]        r_addr;
  logic              r_id;
  logic [0:0]        r_mode;
  logic              r_disp;
  logic              r_err_t, r_err_b, r_err_m;

  // time recovery and frame pulse
  logic [5:0][3:0]   r_time;
  logic              r_tv;
  logic [1:0]        r_fd_pipe;

  // decode results
  logic              w_xfer, w_wr, w_cmd, w_dat, w_short, w_busy_nz;
  logic [6:0]        w_addr_nx;
  logic              w_id_nx;
  logic [0:0]        w_mode_nx;
  logic              w_disp_nx;
  logic              w_clr, w_we, w_dl_err, w_fd_hit;
  logic [BUSY_W-1:0] w_busy_ld;
  logic [7:0]        w_pos_ok;

  assign w_d = {bus.LCD7, bus.LCD6, bus.LCD5, bus.LCD4,
                bus.LCD3, bus.LCD2, bus.LCD1, bus.LCD0};

  // A transfer is E seen high last cycle and low now; it uses last-high bus values.
  assign w_xfer    = r_e_q & ~bus.E;
  assign w_wr      = w_xfer & ~r_rw_q;
  assign w_cmd     = w_wr & ~r_rs_q;
  assign w_dat     = w_wr & r_rs_q;
  // r_ehi counts earlier high cycles; +1 for the cycle ending at this edge.
  assign w_short   = (r_ehi < EHI_W'(EHI_MAX));
  assign w_busy_nz = (r_busy != '0);

  // Register the raw bus every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_q  <= 1'b0;
      r_rs_q <= 1'b0;
      r_rw_q <= 1'b0;
      r_d_q  <= 8'h00;
    end else begin
      r_e_q  <= bus.E;
      r_rs_q <= bus.RS;
      r_rw_q <= bus.RW;
      r_d_q  <= w_d;
    end
  end

  // Saturating count of cycles with E high; cleared while E is low.
  always_ff @(posedge clk) begin
    if (reset || !r_e_q)
      r_ehi <= '0;
    else if (r_ehi != EHI_W'(EHI_MAX))
      r_ehi <= r_ehi + 1'b1;
  end

  // Command/data decode into next-state values for the model.
  always_comb begin
    w_addr_nx = r_addr;
    w_id_nx   = r_id;
    w_mode_nx = r_mode;
    w_disp_nx = r_disp;
    w_clr     = 1'b0;
    w_we      = 1'b0;
    w_dl_err  = 1'b0;
    w_busy_ld = BUSY_W'(CMD_BUSY_CYC);
    if (w_cmd) begin
      casez (r_d_q)
        8'b1???????: begin
          w_addr_nx = r_d_q[6:0];
          w_mode_nx = MODE_DDRAM;
        end
        8'b01??????: w_mode_nx = MODE_CGRAM;
        8'b001?????: w_dl_err = ~r_d_q[4];
        8'b0001????: begin
          if (!r_d_q[3])
            w_addr_nx = r_d_q[2] ? r_addr + 7'd1 : r_addr - 7'd1;
        end
        8'b00001???: w_disp_nx = r_d_q[2];
        8'b000001??: w_id_nx = r_d_q[1];
        8'b0000001?: begin
          w_addr_nx = 7'd0;
          w_mode_nx = MODE_DDRAM;
          w_busy_ld = BUSY_W'(CLR_BUSY_CYC);
        end
        8'b00000001: begin
          w_clr     = 1'b1;
          w_addr_nx = 7'd0;
          w_id_nx   = 1'b1;
          w_mode_nx = MODE_DDRAM;
          w_busy_ld = BUSY_W'(CLR_BUSY_CYC);
        end
        default: ;
      endcase
    end else if (w_dat) begin
      // CGRAM writes and off-screen addresses are dropped but still step addr.
      w_we      = (r_mode == MODE_DDRAM) && (r_addr < 7'd16);
      w_addr_nx = r_id ? r_addr + 7'd1 : r_addr - 7'd1;
    end
  end

  assign w_fd_hit = w_we && (r_addr == 7'(TIME_ADDR + 7));

  // Character model: blank on reset/clear, else take the data write.
  always_ff @(posedge clk) begin
    if (reset || w_clr)
      r_chr <= {NCHR{8'h20}};
    else if (w_we)
      r_chr[r_addr[3:0]] <= r_d_q;
  end

  // Address, entry mode, target RAM and display-on state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= 7'd0;
      r_id   <= 1'b1;
      r_mode <= MODE_DDRAM;
      r_disp <= 1'b0;
    end else begin
      r_addr <= w_addr_nx;
      r_id   <= w_id_nx;
      r_mode <= w_mode_nx;
      r_disp <= w_disp_nx;
    end
  end

  // Busy model: reload on every write, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (reset)
      r_busy <= '0;
    else if (w_wr)
      r_busy <= w_busy_ld;
    else if (w_busy_nz)
      r_busy <= r_busy - 1'b1;
  end

  // Sticky protocol error flags; a read cycle is always a mode error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_t <= 1'b0;
      r_err_b <= 1'b0;
      r_err_m <= 1'b0;
    end else begin
      if (w_xfer && w_short)           r_err_t <= 1'b1;
      if (w_xfer && w_busy_nz)         r_err_b <= 1'b1;
      if ((w_xfer && r_rw_q) || w_dl_err) r_err_m <= 1'b1;
    end
  end

  // Per-position format check: colons at +2/+5, ASCII digits elsewhere.
  for (genvar g = 0; g < 8; g++) begin : g_pos
    localparam int P = TIME_ADDR + g;
    if (g == 2 || g == 5) begin : g_col
      assign w_pos_ok[g] = (r_chr[P] == 8'h3A);
    end else begin : g_dig
      assign w_pos_ok[g] = (r_chr[P] >= 8'h30) && (r_chr[P] <= 8'h39);
    end
  end

  // Register the recovered time one cycle after the model changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_time <= '0;
      r_tv   <= 1'b0;
    end else begin
      r_time <= {r_chr[TIME_ADDR+0][3:0], r_chr[TIME_ADDR+1][3:0],
                 r_chr[TIME_ADDR+3][3:0], r_chr[TIME_ADDR+4][3:0],
                 r_chr[TIME_ADDR+6][3:0], r_chr[TIME_ADDR+7][3:0]};
      r_tv   <= &w_pos_ok;
    end
  end

  // Frame pulse delayed to line up with the refreshed time outputs.
  always_ff @(posedge clk) begin
    if (reset)
      r_fd_pipe <= 2'b00;
    else
      r_fd_pipe <= {r_fd_pipe[0], w_fd_hit};
  end

  assign H1         = r_time[5];
  assign H0         = r_time[4];
  assign M1         = r_time[3];
  assign M0         = r_time[2];
  assign S1         = r_time[1];
  assign S0         = r_time[0];
  assign time_valid = r_tv;
  assign frame_done = r_fd_pipe[1];
  assign disp_on    = r_disp;
  assign err_timing = r_err_t;
  assign err_busy   = r_err_b;
  assign err_mode   = r_err_m;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: table of bus transfers with expected
// display state, plus hand sequences for frame timing and reset mid-pulse.
module tb_lcd_bus_decoder;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] H1, H0, M1, M0, S1, S0;
  logic time_valid, frame_done, disp_on, err_timing, err_busy, err_mode;

  lcd_bus_decoder_if bus ();

  lcd_bus_decoder #(
    .TIME_ADDR   (4),
    .MIN_E_HIGH  (12),
    .CMD_BUSY_CYC(40),
    .CLR_BUSY_CYC(200)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .H1        (H1),
    .H0        (H0),
    .M1        (M1),
    .M0        (M0),
    .S1        (S1),
    .S0        (S0),
    .time_valid(time_valid),
    .frame_done(frame_done),
    .disp_on   (disp_on),
    .err_timing(err_timing),
    .err_busy  (err_busy),
    .err_mode  (err_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic        rw;
    logic [7:0]  d;
    int          ehi;
    int          gap;
    logic [23:0] t;
    logic        tv;
    logic        dsp;
    logic [2:0]  err;
  } vec_t;

  vec_t vec_a [12];
  vec_t vec_b [18];

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;

  wire [23:0] w_t   = {H1, H0, M1, M0, S1, S0};
  wire [2:0]  w_err = {err_timing, err_busy, err_mode};

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      input int ehi, input int gap);
    @(negedge clk);
    bus.E = 1'b1; bus.RS = rs; bus.RW = rw;
    {bus.LCD7, bus.LCD6, bus.LCD5, bus.LCD4,
     bus.LCD3, bus.LCD2, bus.LCD1, bus.LCD0} = d;
    repeat (ehi - 1) @(negedge clk);
    @(negedge clk);
    bus.E = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_vec(input string tag, input int i, input vec_t v);
    xfer(v.rs, v.rw, v.d, v.ehi, v.gap);
    chk($sformatf("%s[%0d] time", tag, i), 32'(w_t), 32'(v.t));
    chk($sformatf("%s[%0d] time_valid", tag, i), 32'(time_valid), 32'(v.tv));
    chk($sformatf("%s[%0d] disp_on", tag, i), 32'(disp_on), 32'(v.dsp));
    chk($sformatf("%s[%0d] err", tag, i), 32'(w_err), 32'(v.err));
  endtask

  function automatic vec_t mk(input logic rs, input logic rw, input logic [7:0] d,
                              input int ehi, input int gap, input logic [23:0] t,
                              input logic tv, input logic dsp, input logic [2:0] err);
    vec_t v;
    v.rs = rs; v.rw = rw; v.d = d; v.ehi = ehi; v.gap = gap;
    v.t = t; v.tv = tv; v.dsp = dsp; v.err = err;
    return v;
  endfunction

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run did not finish within cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    // init sequence then "12:34:56" minus the last digit; 0x38 gap 20 puts the
    // next edge 41 cycles later, exactly when the busy count has reached zero
    vec_a[0]  = mk(0, 0, 8'h38, 20,  20, 24'h000000, 0, 0, 3'b000);
    vec_a[1]  = mk(0, 0, 8'h0C, 20, 250, 24'h000000, 0, 1, 3'b000);
    vec_a[2]  = mk(0, 0, 8'h01, 20, 250, 24'h000000, 0, 1, 3'b000);
    vec_a[3]  = mk(0, 0, 8'h06, 20, 250, 24'h000000, 0, 1, 3'b000);
    vec_a[4]  = mk(0, 0, 8'h84, 20, 250, 24'h000000, 0, 1, 3'b000);
    vec_a[5]  = mk(1, 0, 8'h31, 20, 250, 24'h100000, 0, 1, 3'b000);
    vec_a[6]  = mk(1, 0, 8'h32, 20, 250, 24'h120000, 0, 1, 3'b000);
    vec_a[7]  = mk(1, 0, 8'h3A, 20, 250, 24'h120000, 0, 1, 3'b000);
    vec_a[8]  = mk(1, 0, 8'h33, 20, 250, 24'h123000, 0, 1, 3'b000);
    vec_a[9]  = mk(1, 0, 8'h34, 20, 250, 24'h123400, 0, 1, 3'b000);
    vec_a[10] = mk(1, 0, 8'h3A, 20, 250, 24'h123400, 0, 1, 3'b000);
    vec_a[11] = mk(1, 0, 8'h35, 20, 250, 24'h123450, 0, 1, 3'b000);

    vec_b[0]  = mk(0, 0, 8'h8A, 20, 250, 24'h123456, 1, 1, 3'b000);
    vec_b[1]  = mk(1, 0, 8'h37, 20, 250, 24'h123476, 1, 1, 3'b000);
    vec_b[2]  = mk(0, 0, 8'h85, 20, 250, 24'h123476, 1, 1, 3'b000);
    vec_b[3]  = mk(1, 0, 8'h41, 20, 250, 24'h113476, 0, 1, 3'b000);
    vec_b[4]  = mk(0, 0, 8'h85, 20, 250, 24'h113476, 0, 1, 3'b000);
    vec_b[5]  = mk(1, 0, 8'h39,  5, 250, 24'h193476, 1, 1, 3'b100);
    vec_b[6]  = mk(0, 0, 8'h01, 20, 100, 24'h000000, 0, 1, 3'b100);
    vec_b[7]  = mk(0, 0, 8'h0C, 20, 250, 24'h000000, 0, 1, 3'b110);
    vec_b[8]  = mk(0, 0, 8'h28, 20, 250, 24'h000000, 0, 1, 3'b111);
    vec_b[9]  = mk(0, 0, 8'h84, 20, 250, 24'h000000, 0, 1, 3'b111);
    vec_b[10] = mk(1, 1, 8'h35, 20, 250, 24'h000000, 0, 1, 3'b111);
    vec_b[11] = mk(1, 0, 8'h37, 20, 250, 24'h700000, 0, 1, 3'b111);
    vec_b[12] = mk(0, 0, 8'h04, 20, 250, 24'h700000, 0, 1, 3'b111);
    vec_b[13] = mk(0, 0, 8'h8B, 20, 250, 24'h700000, 0, 1, 3'b111);
    vec_b[14] = mk(1, 0, 8'h39, 20, 250, 24'h700009, 0, 1, 3'b111);
    vec_b[15] = mk(1, 0, 8'h38, 20, 250, 24'h700089, 0, 1, 3'b111);
    vec_b[16] = mk(1, 0, 8'h3A, 20, 250, 24'h700089, 0, 1, 3'b111);
    vec_b[17] = mk(1, 0, 8'h34, 20, 250, 24'h700489, 0, 1, 3'b111);

    // reset and idle
    reset = 1'b1;
    bus.E = 1'b0; bus.RS = 1'b0; bus.RW = 1'b0;
    {bus.LCD7, bus.LCD6, bus.LCD5, bus.LCD4,
     bus.LCD3, bus.LCD2, bus.LCD1, bus.LCD0} = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle time", 32'(w_t), 32'h0);
    chk("idle time_valid", 32'(time_valid), 32'h0);
    chk("idle disp_on", 32'(disp_on), 32'h0);
    chk("idle err", 32'(w_err), 32'h0);
    chk("idle frame_done count", 32'(fd_cnt), 32'h0);

    for (int i = 0; i < 12; i++) run_vec("vec_a", i, vec_a[i]);

    // last seconds digit: outputs lag the model by one edge, pulse follows
    xfer(1, 0, 8'h36, 20, 0);
    @(negedge clk);
    chk("frame t+1 time_valid", 32'(time_valid), 32'h0);
    chk("frame t+1 frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    chk("frame t+2 time", 32'(w_t), 32'h123456);
    chk("frame t+2 time_valid", 32'(time_valid), 32'h1);
    chk("frame t+2 frame_done", 32'(frame_done), 32'h1);
    @(negedge clk);
    chk("frame t+3 frame_done", 32'(frame_done), 32'h0);
    repeat (250) @(negedge clk);
    chk("frame pulse count", 32'(fd_cnt), 32'h1);
    chk("frame err", 32'(w_err), 32'h0);

    for (int i = 0; i < 18; i++) run_vec("vec_b", i, vec_b[i]);

    // reset in the middle of an E-high phase
    @(negedge clk);
    bus.E = 1'b1; bus.RS = 1'b0; bus.RW = 1'b0;
    {bus.LCD7, bus.LCD6, bus.LCD5, bus.LCD4,
     bus.LCD3, bus.LCD2, bus.LCD1, bus.LCD0} = 8'h0C;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst time", 32'(w_t), 32'h0);
    chk("rst time_valid", 32'(time_valid), 32'h0);
    chk("rst frame_done", 32'(frame_done), 32'h0);
    chk("rst disp_on", 32'(disp_on), 32'h0);
    chk("rst err", 32'(w_err), 32'h0);
    @(negedge clk);
    chk("rst chars blank", 32'(w_t), 32'h0);
    repeat (20) @(negedge clk);
    bus.E = 1'b0;
    repeat (2) @(negedge clk);
    chk("post-rst cmd disp_on", 32'(disp_on), 32'h1);
    chk("post-rst cmd err", 32'(w_err), 32'h0);
    // next falling edge lands with the busy count still at 1
    repeat (17) @(negedge clk);
    xfer(0, 0, 8'h08, 20, 250);
    chk("busy=1 disp_on", 32'(disp_on), 32'h0);
    chk("busy=1 err", 32'(w_err), 32'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
